// File: rtl/toy_pack.sv
// ============================================================================
// Module      : toy_pack
// Description : Shared types and constants for the instruction-fetch request
//               controller: the fetch FSM state encoding and the number of
//               bytes covered by one fetch beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toy_pack;

    // Width of one memory fetch beat; each accepted request advances the PC
    // by one beat.
    localparam int DATA_WIDTH  = 64;
    localparam int FETCH_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_e;

endpackage : toy_pack

`default_nettype wire

// File: rtl/toy_fetch_credit_cnt.sv
// ============================================================================
// Module      : toy_fetch_credit_cnt
// Description : Free-credit counter for the fetch path. One credit is taken
//               per accepted fetch; credits come back from stale memory acks
//               and from instruction-queue releases. All three sources are
//               applied in the same cycle.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk           in   clock
//   rst_n         in   synchronous active-low reset
//   fetch_i       in   one credit consumed this cycle
//   stale_i       in   one credit returned by a dropped stale ack
//   release_i     in   credits returned by the instruction queue
//   credit_cnt_o  out  registered free-credit count
// ============================================================================
`default_nettype none

module toy_fetch_credit_cnt #(
    parameter  int CREDIT_DEPTH  = 128,
    parameter  int RELEASE_WIDTH = 3,
    localparam int CNT_WIDTH     = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_i,
    input  logic                     stale_i,
    input  logic [RELEASE_WIDTH-1:0] release_i,
    output logic [CNT_WIDTH-1:0]     credit_cnt_o
);

    // One extra bit over the widest operand so that an over-return or an
    // underflow shows up as a value above CREDIT_DEPTH instead of wrapping
    // silently.
    localparam int SUM_WIDTH =
        ((CNT_WIDTH > RELEASE_WIDTH) ? CNT_WIDTH : RELEASE_WIDTH) + 1;

    logic [CNT_WIDTH-1:0] credit_q;
    logic [CNT_WIDTH-1:0] credit_d;
    logic [SUM_WIDTH-1:0] w_sum;

    always_comb begin
        w_sum    = SUM_WIDTH'(credit_q)
                 - SUM_WIDTH'(fetch_i)
                 + SUM_WIDTH'(stale_i)
                 + SUM_WIDTH'(release_i);
        credit_d = w_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q <= CNT_WIDTH'(CREDIT_DEPTH);
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_cnt_o = credit_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fetch_i && (credit_q == '0)))
                else $error("toy_fetch_credit_cnt: credit underflow");
            assert (w_sum <= SUM_WIDTH'(CREDIT_DEPTH))
                else $error("toy_fetch_credit_cnt: credit overflow");
        end
    end
`endif

endmodule : toy_fetch_credit_cnt

`default_nettype wire

// File: rtl/toy_fetch_req_ctrl.sv
// ============================================================================
// Module      : toy_fetch_req_ctrl
// Description : Instruction-fetch request sequencer. Owns the fetch PC, the
//               entry-id allocation ring, the branch tag and the credit pool.
//               A redirect produces a one-cycle cancel pulse during which the
//               branch tag advances, keeping it in lock-step with the
//               downstream branch filter. Acks carrying a tag the filter will
//               drop are recovered here as credits.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk                  in   clock
//   rst_n                in   synchronous active-low reset
//   fetch_en             in   enable fetching
//   redirect_en          in   redirect / flush request
//   redirect_pc          in   new fetch PC
//   fetch_req_vld        out  request valid
//   fetch_req_rdy        in   memory accepts request
//   fetch_req_addr       out  fetch address (current PC)
//   fetch_req_branch_id  out  branch tag of request
//   fetch_req_entry_id   out  allocated entry id
//   mem_ack_vld          in   memory ack valid
//   mem_ack_branch_id    in   branch tag carried by the ack
//   iq_release_cnt       in   entries freed by the instruction queue
//   cancel_edge_en       out  one-cycle cancel pulse to branch filter
//   credit_cnt           out  registered free-credit count
// ============================================================================
`default_nettype none

module toy_fetch_req_ctrl
    import toy_pack::*;
#(
    parameter  int                    BRANCH_WIDTH  = 3,
    parameter  int                    CREDIT_DEPTH  = 128,
    parameter  int                    ADDR_WIDTH    = 32,
    parameter  logic [ADDR_WIDTH-1:0] BOOT_PC       = '0,
    parameter  int                    RELEASE_WIDTH = 3,
    localparam int                    ENTRY_WIDTH   = $clog2(CREDIT_DEPTH),
    localparam int                    CNT_WIDTH     = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     redirect_en,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic                     fetch_req_vld,
    input  logic                     fetch_req_rdy,
    output logic [ADDR_WIDTH-1:0]    fetch_req_addr,
    output logic [BRANCH_WIDTH-1:0]  fetch_req_branch_id,
    output logic [ENTRY_WIDTH-1:0]   fetch_req_entry_id,
    input  logic                     mem_ack_vld,
    input  logic [BRANCH_WIDTH-1:0]  mem_ack_branch_id,
    input  logic [RELEASE_WIDTH-1:0] iq_release_cnt,
    output logic                     cancel_edge_en,
    output logic [CNT_WIDTH-1:0]     credit_cnt
);

    localparam logic [ENTRY_WIDTH-1:0] c_last_entry = ENTRY_WIDTH'(CREDIT_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0]  c_pc_step    = ADDR_WIDTH'(FETCH_BYTES);

    fetch_state_e            state_q;
    fetch_state_e            state_d;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   pc_d;
    logic [BRANCH_WIDTH-1:0] branch_id_q;
    logic [BRANCH_WIDTH-1:0] branch_id_d;
    logic [ENTRY_WIDTH-1:0]  alloc_ptr_q;
    logic [ENTRY_WIDTH-1:0]  alloc_ptr_d;
    logic [CNT_WIDTH-1:0]    credit_q;

    logic                    w_vld;
    logic                    w_cancel;
    logic                    w_fire;
    logic                    w_pending;
    logic                    w_ack_stale;
    logic [BRANCH_WIDTH-1:0] w_branch_id_inc;

    // Outputs decode registered state only, so they are glitch-free and the
    // issue decision never sees same-cycle credit returns.
    assign w_cancel  = (state_q == REDIRECT);
    assign w_vld     = (state_q == FETCH) && (credit_q != '0);
    assign w_fire    = w_vld && fetch_req_rdy;
    assign w_pending = w_vld && !fetch_req_rdy;

    assign w_branch_id_inc = branch_id_q + BRANCH_WIDTH'(1);

    // During the cancel cycle the filter already accepts the incremented tag,
    // so an ack carrying it is live. An ack with the pre-increment tag is
    // also forwarded; the IQ flushes it and returns it via iq_release_cnt.
    assign w_ack_stale = mem_ack_vld
                      && (mem_ack_branch_id != branch_id_q)
                      && !(w_cancel && (mem_ack_branch_id == w_branch_id_inc));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        branch_id_d = branch_id_q;
        alloc_ptr_d = alloc_ptr_q;

        // Entry ids are handed out in order; the IQ frees them in order, so
        // the ring pointer survives redirects untouched.
        if (w_fire) begin
            pc_d        = pc_q + c_pc_step;
            alloc_ptr_d = (alloc_ptr_q == c_last_entry) ? '0
                        : alloc_ptr_q + ENTRY_WIDTH'(1);
        end

        if (w_cancel) begin
            branch_id_d = w_branch_id_inc;
        end

        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A presented-but-unaccepted request must stay up until taken.
                if (!fetch_en && !w_pending) begin
                    state_d = IDLE;
                end
            end
            REDIRECT: begin
                state_d = fetch_en ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides everything, including a same-cycle PC advance.
        // Any pending request is withdrawn because REDIRECT drives vld low.
        if (redirect_en) begin
            state_d = REDIRECT;
            pc_d    = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= BOOT_PC;
            branch_id_q <= '0;
            alloc_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            branch_id_q <= branch_id_d;
            alloc_ptr_q <= alloc_ptr_d;
        end
    end

    toy_fetch_credit_cnt #(
        .CREDIT_DEPTH  (CREDIT_DEPTH),
        .RELEASE_WIDTH (RELEASE_WIDTH)
    ) u_credit_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_i      (w_fire),
        .stale_i      (w_ack_stale),
        .release_i    (iq_release_cnt),
        .credit_cnt_o (credit_q)
    );

    assign fetch_req_vld       = w_vld;
    assign fetch_req_addr      = pc_q;
    assign fetch_req_branch_id = branch_id_q;
    assign fetch_req_entry_id  = alloc_ptr_q;
    assign cancel_edge_en      = w_cancel;
    assign credit_cnt          = credit_q;

endmodule : toy_fetch_req_ctrl

`default_nettype wire

// File: tb/tb_toy_fetch_req_ctrl.sv
// ============================================================================
// Module      : tb_toy_fetch_req_ctrl
// Description : Directed self-checking bench for toy_fetch_req_ctrl with a
//               four-entry credit pool and 8-byte fetch beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toy_fetch_req_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        fetch_req_vld;
    logic        fetch_req_rdy;
    logic [31:0] fetch_req_addr;
    logic [2:0]  fetch_req_branch_id;
    logic [1:0]  fetch_req_entry_id;
    logic        mem_ack_vld;
    logic [2:0]  mem_ack_branch_id;
    logic [2:0]  iq_release_cnt;
    logic        cancel_edge_en;
    logic [2:0]  credit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    toy_fetch_req_ctrl #(
        .BRANCH_WIDTH  (3),
        .CREDIT_DEPTH  (4),
        .ADDR_WIDTH    (32),
        .BOOT_PC       (32'h0000_0000),
        .RELEASE_WIDTH (3)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch_en            (fetch_en),
        .redirect_en         (redirect_en),
        .redirect_pc         (redirect_pc),
        .fetch_req_vld       (fetch_req_vld),
        .fetch_req_rdy       (fetch_req_rdy),
        .fetch_req_addr      (fetch_req_addr),
        .fetch_req_branch_id (fetch_req_branch_id),
        .fetch_req_entry_id  (fetch_req_entry_id),
        .mem_ack_vld         (mem_ack_vld),
        .mem_ack_branch_id   (mem_ack_branch_id),
        .iq_release_cnt      (iq_release_cnt),
        .cancel_edge_en      (cancel_edge_en),
        .credit_cnt          (credit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_en    = 1'b0;
        redirect_pc    = '0;
        fetch_req_rdy  = 1'b0;
        mem_ack_vld    = 1'b0;
        mem_ack_branch_id = '0;
        iq_release_cnt = '0;

        step();
        step();
        check_val("rst_vld",    32'(fetch_req_vld),       32'd0);
        check_val("rst_cancel", 32'(cancel_edge_en),      32'd0);
        check_val("rst_credit", 32'(credit_cnt),          32'd4);
        check_val("rst_addr",   fetch_req_addr,           32'h0);
        check_val("rst_tag",    32'(fetch_req_branch_id), 32'd0);
        check_val("rst_entry",  32'(fetch_req_entry_id),  32'd0);

        // Four back-to-back requests drain the credit pool.
        rst_n         = 1'b1;
        fetch_en      = 1'b1;
        fetch_req_rdy = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("burst_vld%0d", i),   32'(fetch_req_vld),       32'd1);
            check_val($sformatf("burst_addr%0d", i),  fetch_req_addr,           32'(i * 8));
            check_val($sformatf("burst_entry%0d", i), 32'(fetch_req_entry_id),  32'(i));
            check_val($sformatf("burst_tag%0d", i),   32'(fetch_req_branch_id), 32'd0);
            step();
        end
        check_val("drained_vld",    32'(fetch_req_vld),      32'd0);
        check_val("drained_credit", 32'(credit_cnt),         32'd0);
        check_val("drained_entry",  32'(fetch_req_entry_id), 32'd0);

        // Release two entries: two more requests, entry ids wrap to 0,1.
        iq_release_cnt = 3'd2;
        step();
        iq_release_cnt = 3'd0;
        check_val("rel_credit", 32'(credit_cnt),         32'd2);
        check_val("rel_vld",    32'(fetch_req_vld),      32'd1);
        check_val("rel_entry0", 32'(fetch_req_entry_id), 32'd0);
        check_val("rel_addr0",  fetch_req_addr,          32'd32);
        step();
        check_val("rel_entry1", 32'(fetch_req_entry_id), 32'd1);
        check_val("rel_addr1",  fetch_req_addr,          32'd40);
        check_val("rel_credit1", 32'(credit_cnt),        32'd1);
        step();
        check_val("rel_vld_end",    32'(fetch_req_vld), 32'd0);
        check_val("rel_credit_end", 32'(credit_cnt),    32'd0);

        iq_release_cnt = 3'd3;
        step();
        iq_release_cnt = 3'd0;
        check_val("rel3_credit", 32'(credit_cnt),    32'd3);
        check_val("rel3_vld",    32'(fetch_req_vld), 32'd1);

        // Single redirect; pending request (rdy=0) is withdrawn.
        redirect_en   = 1'b1;
        redirect_pc   = 32'h100;
        fetch_req_rdy = 1'b0;
        step();
        redirect_en = 1'b0;
        check_val("redir_cancel", 32'(cancel_edge_en),      32'd1);
        check_val("redir_vld",    32'(fetch_req_vld),       32'd0);
        check_val("redir_tag0",   32'(fetch_req_branch_id), 32'd0);
        step();
        check_val("redir_cancel_off", 32'(cancel_edge_en),      32'd0);
        check_val("redir_new_vld",    32'(fetch_req_vld),       32'd1);
        check_val("redir_new_addr",   fetch_req_addr,           32'h100);
        check_val("redir_new_tag",    32'(fetch_req_branch_id), 32'd1);
        check_val("redir_entry",      32'(fetch_req_entry_id),  32'd2);
        check_val("redir_credit",     32'(credit_cnt),          32'd3);

        // Stale ack (old tag 0) returns a credit; live ack (tag 1) does not.
        mem_ack_vld       = 1'b1;
        mem_ack_branch_id = 3'd0;
        step();
        check_val("stale_credit", 32'(credit_cnt), 32'd4);
        mem_ack_branch_id = 3'd1;
        step();
        mem_ack_vld = 1'b0;
        check_val("live_credit", 32'(credit_cnt), 32'd4);

        // redirect_en held three cycles: three pulses, tag 1 -> 4.
        redirect_en = 1'b1;
        redirect_pc = 32'h200;
        step();
        check_val("hold_cancel1", 32'(cancel_edge_en),      32'd1);
        check_val("hold_tag1",    32'(fetch_req_branch_id), 32'd1);
        redirect_pc = 32'h300;
        step();
        check_val("hold_cancel2", 32'(cancel_edge_en),      32'd1);
        check_val("hold_tag2",    32'(fetch_req_branch_id), 32'd2);
        redirect_pc = 32'h400;
        step();
        redirect_en = 1'b0;
        check_val("hold_cancel3", 32'(cancel_edge_en),      32'd1);
        check_val("hold_tag3",    32'(fetch_req_branch_id), 32'd3);
        check_val("hold_addr3",   fetch_req_addr,           32'h400);
        // Ack with tag+1 during the cancel cycle is live: no credit change.
        mem_ack_vld       = 1'b1;
        mem_ack_branch_id = 3'd4;
        step();
        mem_ack_vld = 1'b0;
        check_val("hold_cancel_off", 32'(cancel_edge_en),      32'd0);
        check_val("hold_tag_final",  32'(fetch_req_branch_id), 32'd4);
        check_val("hold_addr_final", fetch_req_addr,           32'h400);
        check_val("hold_credit",     32'(credit_cnt),          32'd4);
        check_val("hold_vld",        32'(fetch_req_vld),       32'd1);

        // Request held with rdy=0 for five cycles; fetch_en dropped midway.
        for (int i = 0; i < 5; i++) begin
            if (i == 2) fetch_en = 1'b0;
            step();
            check_val($sformatf("stall_vld%0d", i),   32'(fetch_req_vld),       32'd1);
            check_val($sformatf("stall_addr%0d", i),  fetch_req_addr,           32'h400);
            check_val($sformatf("stall_tag%0d", i),   32'(fetch_req_branch_id), 32'd4);
            check_val($sformatf("stall_entry%0d", i), 32'(fetch_req_entry_id),  32'd2);
        end
        fetch_req_rdy = 1'b1;
        step();
        check_val("accept_vld",    32'(fetch_req_vld),      32'd0);
        check_val("accept_addr",   fetch_req_addr,          32'h408);
        check_val("accept_entry",  32'(fetch_req_entry_id), 32'd3);
        check_val("accept_credit", 32'(credit_cnt),         32'd3);
        step();
        check_val("idle_vld", 32'(fetch_req_vld), 32'd0);

        // Fetch, stale ack and release applied together in one cycle.
        fetch_en = 1'b1;
        step();
        check_val("combo_vld", 32'(fetch_req_vld), 32'd1);
        mem_ack_vld       = 1'b1;
        mem_ack_branch_id = 3'd0;
        iq_release_cnt    = 3'd1;
        step();
        mem_ack_vld    = 1'b0;
        iq_release_cnt = 3'd0;
        fetch_en       = 1'b0;
        fetch_req_rdy  = 1'b0;
        check_val("combo_credit", 32'(credit_cnt),         32'd4);
        check_val("combo_entry",  32'(fetch_req_entry_id), 32'd0);
        check_val("combo_addr",   fetch_req_addr,          32'h410);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_toy_fetch_req_ctrl

`default_nettype wire
